// File: rtl/vga_pkg.sv
// vga_pkg: test-pattern enum and default 640x480@60 raster constants shared by
// vga_timing_gen and vga_pattern.
package vga_pkg;

  typedef enum logic [1:0] {
    BLACK    = 2'd0,
    BARS     = 2'd1,
    CHECKER  = 2'd2,
    GRADIENT = 2'd3
  } pattern_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/vga_pattern.sv
// vga_pattern: combinational test-pattern colour for the current raster position.
// Coordinate bit fields are pre-extracted by the parent so widths stay generic.
module vga_pattern
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int CW       = 1,
  parameter int XW       = 10
) (
  input  logic [XW-1:0] hcnt,
  input  logic [CW-1:0] xg,
  input  logic [CW-1:0] yg,
  input  logic          x5,
  input  logic          y5,
  input  pattern_e      mode,
  input  logic          de,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b
);

  logic [2:0] w_bar;

  // Bar index from constant thresholds; H_ACTIVE is a multiple of 8.
  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(hcnt) >= k * (H_ACTIVE / 8)) w_bar = 3'(k);
    end
  end

  always_comb begin
    r = '0;
    g = '0;
    b = '0;
    if (de) begin
      case (mode)
        BARS: begin
          r = {CW{w_bar[2]}};
          g = {CW{w_bar[1]}};
          b = {CW{w_bar[0]}};
        end
        CHECKER: begin
          if (x5 ^ y5) begin
            r = '1;
            g = '1;
            b = '1;
          end
        end
        GRADIENT: begin
          r = xg;
          g = yg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with registered sync/de/strobes and pattern RGB.
// Define VGA_CE_EN to add the pix_ce pixel clock-enable port.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = 1,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW       = $clog2(H_TOTAL),
  localparam int YW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef VGA_CE_EN
  input  logic          pix_ce,
`endif
  input  pattern_e      mode_i,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b
);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $error("vga_timing_gen: porch and sync widths must be at least 1");
  end
  if (CW < 1 || CW > 8) begin : g_bad_cw
    $error("vga_timing_gen: CW must be in 1..8");
  end
  if (H_ACTIVE % 8 != 0) begin : g_bad_ha
    $error("vga_timing_gen: H_ACTIVE must be a multiple of 8");
  end

  localparam logic [XW-1:0] HA     = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_B   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_E   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] VA     = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_B   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_E   = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);

  logic [XW-1:0] r_hcnt, r_x;
  logic [YW-1:0] r_vcnt, r_y;
  pattern_e      r_mode;
  logic          r_hsync, r_vsync, r_de, r_line_start, r_frame_start;
  logic [CW-1:0] r_r, r_g, r_b;

  logic          w_ce, w_h_last, w_v_last, w_de, w_hs_act, w_vs_act;
  logic          w_x5, w_y5;
  logic [CW-1:0] w_xg, w_yg, w_r, w_g, w_b;

`ifdef VGA_CE_EN
  assign w_ce = pix_ce;
`else
  assign w_ce = 1'b1;
`endif

  assign w_h_last = (r_hcnt == H_LAST);
  assign w_v_last = (r_vcnt == V_LAST);
  assign w_de     = (r_hcnt < HA) && (r_vcnt < VA);
  assign w_hs_act = (r_hcnt >= HS_B) && (r_hcnt < HS_E);
  assign w_vs_act = (r_vcnt >= VS_B) && (r_vcnt < VS_E);

  // Coordinate bits beyond the counter width read as zero for small rasters.
  for (genvar i = 0; i < CW; i++) begin : g_grad
    if (i + 3 < XW) begin : g_xb
      assign w_xg[i] = r_hcnt[i+3];
    end else begin : g_xz
      assign w_xg[i] = 1'b0;
    end
    if (i + 3 < YW) begin : g_yb
      assign w_yg[i] = r_vcnt[i+3];
    end else begin : g_yz
      assign w_yg[i] = 1'b0;
    end
  end

  if (XW > 5) begin : g_x5
    assign w_x5 = r_hcnt[5];
  end else begin : g_x5z
    assign w_x5 = 1'b0;
  end
  if (YW > 5) begin : g_y5
    assign w_y5 = r_vcnt[5];
  end else begin : g_y5z
    assign w_y5 = 1'b0;
  end

  vga_pattern #(
    .H_ACTIVE(H_ACTIVE),
    .CW      (CW),
    .XW      (XW)
  ) u_pattern (
    .hcnt(r_hcnt),
    .xg  (w_xg),
    .yg  (w_yg),
    .x5  (w_x5),
    .y5  (w_y5),
    .mode(r_mode),
    .de  (w_de),
    .r   (w_r),
    .g   (w_g),
    .b   (w_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_de          <= 1'b0;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_mode        <= BLACK;
      r_r           <= '0;
      r_g           <= '0;
      r_b           <= '0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (w_ce) begin
        r_hcnt <= w_h_last ? '0 : r_hcnt + 1'b1;
        if (w_h_last) r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
        // Pattern changes only take effect at a frame boundary.
        if (w_h_last && w_v_last) r_mode <= mode_i;
        r_x           <= r_hcnt;
        r_y           <= r_vcnt;
        r_de          <= w_de;
        r_hsync       <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
        r_vsync       <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
        r_line_start  <= (r_hcnt == '0);
        r_frame_start <= (r_hcnt == '0) && (r_vcnt == '0);
        r_r           <= w_r;
        r_g           <= w_g;
        r_b           <= w_b;
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign r           = r_r;
  assign g           = r_g;
  assign b           = r_b;

endmodule
